// File: rtl/param_loader_pkg.sv
// Shared conv-weight loader definitions: parameter sizing, layer word counts, FSM encoding
// and the byte-stream to parameter-word reordering helper.
package param_loader_pkg;

  localparam int unsigned PARSIZE        = 16;
  localparam int unsigned NUM_PARAMS     = 9;
  localparam int unsigned WORD_W         = PARSIZE * NUM_PARAMS;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned BYTES_PER_WORD = WORD_W / BYTE_W;
  localparam int unsigned BYTE_CNT_W     = 5;
  localparam int unsigned ADDR_W         = 12;

  localparam logic [ADDR_W-1:0] CONV1_WORDS     = 12'd16;
  localparam logic [ADDR_W-1:0] CONV2_WORDS     = 12'd512;
  localparam logic [ADDR_W-1:0] CONV3_WORDS     = 12'd2048;
  localparam logic [ADDR_W-1:0] TOTAL_WORDS_DEF = CONV1_WORDS + CONV2_WORDS + CONV3_WORDS;

  localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(BYTES_PER_WORD - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Shift register holds byte 0 at the top; param k must land at bits [16k+15:16k].
  function automatic logic [WORD_W-1:0] order_params(input logic [WORD_W-1:0] sr);
    logic [WORD_W-1:0] w;
    w = '0;
    for (int unsigned k = 0; k < NUM_PARAMS; k++) begin
      w[k*PARSIZE +: PARSIZE] = sr[WORD_W-1-k*PARSIZE -: PARSIZE];
    end
    return w;
  endfunction

endpackage

// File: rtl/param_loader_word_assembler.sv
// Shifts in 18 stream bytes and captures the reordered 144-bit word when the last one arrives.
module param_loader_word_assembler
  import param_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              shift_en,
  input  logic              capture,
  input  logic [BYTE_W-1:0] in_byte,
  output logic [WORD_W-1:0] word
);

  logic [WORD_W-1:0] sr;
  logic [WORD_W-1:0] sr_next;

  assign sr_next = {sr[WORD_W-BYTE_W-1:0], in_byte};

  // word only changes on capture so it holds the last written value between writes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr   <= '0;
      word <= '0;
    end else begin
      if (shift_en) sr <= sr_next;
      if (capture) word <= order_params(sr_next);
    end
  end

endmodule

// File: rtl/param_loader.sv
// Loads conv weights from a byte stream into mem_conv_w port B, one 144-bit word per 18 bytes.
module param_loader
  import param_loader_pkg::*;
#(
  parameter logic [ADDR_W-1:0] TOTAL_WORDS = TOTAL_WORDS_DEF,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 12'd0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_WORD = TOTAL_WORDS - ADDR_W'(1);

  state_t                  state;
  logic [ADDR_W-1:0]       word_cnt;
  logic [BYTE_CNT_W-1:0]   byte_cnt;
  logic                    accept;
  logic                    last_byte;

  assign accept    = in_valid && in_ready;
  assign last_byte = accept && (byte_cnt == LAST_BYTE);

  param_loader_word_assembler u_asm (
    .clk      (clk),
    .rst      (rst),
    .shift_en (accept),
    .capture  (last_byte),
    .in_byte  (in_data),
    .word     (wr_data)
  );

  // Outputs are registered alongside the state so they always reflect the current state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      word_cnt <= '0;
      byte_cnt <= '0;
      in_ready <= 1'b0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state    <= ST_RECV;
            word_cnt <= '0;
            byte_cnt <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            done     <= 1'b0;
          end
        end
        ST_RECV: begin
          if (accept) begin
            if (last_byte) begin
              state    <= ST_WRITE;
              byte_cnt <= '0;
              in_ready <= 1'b0;
              wr_en    <= 1'b1;
              wr_addr  <= BASE_ADDR + word_cnt;
            end else begin
              byte_cnt <= byte_cnt + BYTE_CNT_W'(1);
            end
          end
        end
        ST_WRITE: begin
          if (word_cnt < LAST_WORD) begin
            state    <= ST_RECV;
            word_cnt <= word_cnt + ADDR_W'(1);
            in_ready <= 1'b1;
          end else begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_param_loader.sv
// Directed bench: a 3-word loader for protocol/reset scenarios and a default-size loader for a full load.
module tb_param_loader;
  import param_loader_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              start1, in_valid1, in_ready1, wr_en1, busy1, done1;
  logic [7:0]        in_data1;
  logic [11:0]       wr_addr1;
  logic [143:0]      wr_data1;
  logic              start2, in_valid2, in_ready2, wr_en2, busy2, done2;
  logic [7:0]        in_data2;
  logic [11:0]       wr_addr2;
  logic [143:0]      wr_data2;

  param_loader #(.TOTAL_WORDS(12'd3), .BASE_ADDR(12'd0)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .in_valid(in_valid1), .in_data(in_data1),
    .in_ready(in_ready1), .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
    .busy(busy1), .done(done1)
  );

  param_loader dut2 (
    .clk(clk), .rst(rst), .start(start2), .in_valid(in_valid2), .in_data(in_data2),
    .in_ready(in_ready2), .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
    .busy(busy2), .done(done2)
  );

  int checks = 0;
  int passed = 0;

  logic [11:0]  addr_q[$];
  logic [143:0] data_q[$];
  int           rdy_viol = 0;
  int           wr2_cnt = 0;
  logic [143:0] word16 = '0;

  // write logger, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst && wr_en1) begin
      addr_q.push_back(wr_addr1);
      data_q.push_back(wr_data1);
      if (in_ready1) rdy_viol <= rdy_viol + 1;
    end
    if (!rst && wr_en2) begin
      wr2_cnt <= wr2_cnt + 1;
      if (wr_addr2 == 12'd16) word16 <= wr_data2;
    end
  end

  function automatic logic [143:0] exp_lin(input int base);
    logic [143:0] e;
    for (int k = 0; k < 9; k++) e[16*k +: 16] = {8'(base + 2*k), 8'(base + 2*k + 1)};
    return e;
  endfunction

  function automatic logic [7:0] byte_of(input int i);
    return 8'((i * 7 + 3) & 255);
  endfunction

  task automatic send1(input logic [7:0] b);
    logic ok;
    int n;
    in_valid1 = 1'b1;
    in_data1  = b;
    n = 0;
    do begin
      ok = in_ready1;
      @(posedge clk); #1;
      n++;
    end while (!ok && n < 50);
    in_valid1 = 1'b0;
    if (!ok) begin
      checks++;
      $display("FAIL send1_timeout: in_ready=0 for 50 cycles, required 1 (byte %02h)", b);
    end
  endtask

  task automatic pulse_start1();
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready1 !== 1'b0) $display("FAIL rst_in_ready: got %b want 0", in_ready1); else passed++;
    checks++; if (wr_en1 !== 1'b0) $display("FAIL rst_wr_en: got %b want 0", wr_en1); else passed++;
    checks++; if (wr_addr1 !== 12'd0) $display("FAIL rst_wr_addr: got %h want 000", wr_addr1); else passed++;
    checks++; if (wr_data1 !== 144'd0) $display("FAIL rst_wr_data: got %h want 0", wr_data1); else passed++;
    checks++; if (busy1 !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy1); else passed++;
    checks++; if (done1 !== 1'b0) $display("FAIL rst_done: got %b want 0", done1); else passed++;
    rst = 1'b0;
    // bytes offered in IDLE must not be consumed
    in_valid1 = 1'b1; in_data1 = 8'hEE;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready1 !== 1'b0) $display("FAIL idle_in_ready: got %b want 0", in_ready1); else passed++;
    in_valid1 = 1'b0;
  endtask

  task automatic test_single_word();
    pulse_start1();
    checks++; if (busy1 !== 1'b1 || in_ready1 !== 1'b1 || done1 !== 1'b0)
      $display("FAIL start_flags: busy/in_ready/done got %b%b%b want 110", busy1, in_ready1, done1); else passed++;
    for (int j = 0; j < 18; j++) send1(8'(j));
    checks++; if (wr_en1 !== 1'b1) $display("FAIL w0_latency_wr_en: got %b want 1", wr_en1); else passed++;
    checks++; if (wr_addr1 !== 12'd0) $display("FAIL w0_addr: got %h want 000", wr_addr1); else passed++;
    checks++; if (in_ready1 !== 1'b0) $display("FAIL w0_write_in_ready: got %b want 0", in_ready1); else passed++;
    checks++; if (wr_data1[15:0] !== 16'h0001) $display("FAIL w0_param0: got %h want 0001", wr_data1[15:0]); else passed++;
    checks++; if (wr_data1[143:128] !== 16'h1011) $display("FAIL w0_param8: got %h want 1011", wr_data1[143:128]); else passed++;
    @(posedge clk); #1;
    checks++; if (wr_en1 !== 1'b0 || in_ready1 !== 1'b1) $display("FAIL w0_after: wr_en/in_ready got %b%b want 01", wr_en1, in_ready1); else passed++;
    checks++; if (wr_data1 !== exp_lin(0)) $display("FAIL w0_data_hold: got %h want %h", wr_data1, exp_lin(0)); else passed++;
    checks++; if (addr_q.size() != 1) $display("FAIL w0_count: got %0d want 1", addr_q.size()); else passed++;
  endtask

  task automatic test_start_ignored();
    for (int j = 0; j < 5; j++) send1(8'(18 + j));
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    checks++; if (busy1 !== 1'b1 || done1 !== 1'b0 || in_ready1 !== 1'b1)
      $display("FAIL recv_start: busy/done/in_ready got %b%b%b want 101", busy1, done1, in_ready1); else passed++;
    for (int j = 5; j < 18; j++) send1(8'(18 + j));
    @(posedge clk); #1;
    checks++; if (addr_q.size() != 2) $display("FAIL w1_count: got %0d want 2", addr_q.size());
    else begin
      passed++;
      checks++; if (addr_q[1] !== 12'd1) $display("FAIL w1_addr: got %h want 001", addr_q[1]); else passed++;
      checks++; if (data_q[1] !== exp_lin(18)) $display("FAIL w1_data: got %h want %h", data_q[1], exp_lin(18)); else passed++;
    end
  endtask

  task automatic test_gaps();
    int gap;
    for (int j = 0; j < 18; j++) begin
      send1(8'(36 + j));
      if (j != 17) begin
        gap = (j % 4 == 2) ? 3 : ((j % 5 == 0) ? 1 : 0);
        for (int g = 0; g < gap; g++) begin
          in_data1 = 8'hCC;
          @(posedge clk); #1;
        end
      end
    end
    checks++; if (wr_en1 !== 1'b1 || in_ready1 !== 1'b0 || wr_addr1 !== 12'd2)
      $display("FAIL w2_write: wr_en/in_ready got %b%b addr %h want 10 addr 002", wr_en1, in_ready1, wr_addr1); else passed++;
    @(posedge clk); #1;
    checks++; if (done1 !== 1'b1 || busy1 !== 1'b0 || wr_en1 !== 1'b0)
      $display("FAIL load_done: done/busy/wr_en got %b%b%b want 100", done1, busy1, wr_en1); else passed++;
    in_valid1 = 1'b1; in_data1 = 8'hEE;
    repeat (4) @(posedge clk);
    #1;
    in_valid1 = 1'b0;
    checks++; if (in_ready1 !== 1'b0 || done1 !== 1'b1) $display("FAIL done_hold: in_ready/done got %b%b want 01", in_ready1, done1); else passed++;
    checks++; if (addr_q.size() != 3) $display("FAIL total_writes: got %0d want 3", addr_q.size());
    else begin
      passed++;
      checks++; if (addr_q[0] !== 12'd0 || addr_q[2] !== 12'd2) $display("FAIL write_addrs: got %h,%h want 000,002", addr_q[0], addr_q[2]); else passed++;
      checks++; if (data_q[2] !== exp_lin(36)) $display("FAIL w2_data: got %h want %h", data_q[2], exp_lin(36)); else passed++;
    end
    checks++; if (rdy_viol != 0) $display("FAIL write_in_ready: %0d WRITE cycles with in_ready=1, want 0", rdy_viol); else passed++;
  endtask

  task automatic test_reset_mid();
    pulse_start1();
    checks++; if (done1 !== 1'b0 || busy1 !== 1'b1) $display("FAIL restart: done/busy got %b%b want 01", done1, busy1); else passed++;
    for (int j = 0; j < 18; j++) send1(8'(8'h40 + j));
    for (int j = 0; j < 10; j++) send1(8'(8'h60 + j));
    rst = 1'b1;
    #2;
    checks++; if (in_ready1 !== 1'b0 || busy1 !== 1'b0 || wr_data1 !== 144'd0 || wr_addr1 !== 12'd0)
      $display("FAIL async_rst: in_ready/busy got %b%b data %h addr %h want 00 data 0 addr 000", in_ready1, busy1, wr_data1, wr_addr1); else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
    addr_q.delete();
    data_q.delete();
    pulse_start1();
    for (int j = 0; j < 18; j++) send1(8'(8'hA0 + j));
    @(posedge clk); #1;
    checks++; if (addr_q.size() != 1) $display("FAIL rst_reload_count: got %0d want 1", addr_q.size());
    else begin
      passed++;
      checks++; if (addr_q[0] !== 12'd0) $display("FAIL rst_reload_addr: got %h want 000", addr_q[0]); else passed++;
      checks++; if (data_q[0] !== exp_lin(8'hA0)) $display("FAIL rst_reload_data: got %h want %h", data_q[0], exp_lin(8'hA0)); else passed++;
    end
  endtask

  task automatic test_full_load();
    int i;
    int guard;
    logic ok;
    logic [143:0] e16;
    for (int k = 0; k < 9; k++) e16[16*k +: 16] = {byte_of(288 + 2*k), byte_of(288 + 2*k + 1)};
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    i = 0;
    guard = 0;
    in_valid2 = 1'b1;
    while (i < 46368 && guard < 60000) begin
      in_data2 = byte_of(i);
      ok = in_ready2;
      @(posedge clk); #1;
      if (ok) i++;
      guard++;
    end
    in_valid2 = 1'b0;
    checks++; if (i != 46368) $display("FAIL full_stream: accepted %0d bytes, want 46368", i); else passed++;
    checks++; if (wr_en2 !== 1'b1 || wr_addr2 !== 12'd2575 || done2 !== 1'b0)
      $display("FAIL full_last_write: wr_en %b addr %0d done %b want 1, 2575, 0", wr_en2, wr_addr2, done2); else passed++;
    @(posedge clk); #1;
    checks++; if (done2 !== 1'b1 || busy2 !== 1'b0) $display("FAIL full_done: done/busy got %b%b want 10", done2, busy2); else passed++;
    checks++; if (wr2_cnt != 2576) $display("FAIL full_writes: got %0d want 2576", wr2_cnt); else passed++;
    checks++; if (word16 !== e16) $display("FAIL full_addr16: got %h want %h", word16, e16); else passed++;
  endtask

  initial begin
    start1 = 1'b0; in_valid1 = 1'b0; in_data1 = 8'h00;
    start2 = 1'b0; in_valid2 = 1'b0; in_data2 = 8'h00;
    rst = 1'b1;
    test_reset();
    test_single_word();
    test_start_ignored();
    test_gaps();
    test_reset_mid();
    test_full_load();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
